// File: rtl/seq_shifter_pkg.sv
// Shared types and constants for the multi-cycle shifter.
package shifter_pkg;

    localparam int MAX_STEP = 3;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_shifter_if.sv
// Operand/result handshake bundle between the operand source, the shifter and writeback.
interface seq_shifter_if
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
);
    localparam int SW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d_in;
    logic [SW-1:0]    shamt;
    op_t              op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d_out;

    modport master (
        output in_valid, d_in, shamt, op, out_ready,
        input  in_ready, out_valid, d_out
    );

    modport slave (
        input  in_valid, d_in, shamt, op, out_ready,
        output in_ready, out_valid, d_out
    );

endinterface

// File: rtl/seq_shifter_shift_step.sv
// One combinational shift stage: moves the operand by 0..3 positions with op-dependent fill.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic [WIDTH-1:0] i_data,
    input  op_t              i_op,
    input  logic [1:0]       i_step,
    output wire  [WIDTH-1:0] o_data
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        wire  [MAX_STEP:0] w_lsl;
        wire  [MAX_STEP:0] w_lsr;
        wire  [MAX_STEP:0] w_asr;
        wire  [MAX_STEP:0] w_ror;
        logic [MAX_STEP:0] w_sel;

        // Each candidate vector holds this bit's source for a shift of 0..3.
        for (genvar s = 0; s <= MAX_STEP; s++) begin : g_src
            if (i >= s) begin : g_lo
                assign w_lsl[s] = i_data[i-s];
            end else begin : g_lo_fill
                assign w_lsl[s] = 1'b0;
            end

            if (i + s < WIDTH) begin : g_hi
                assign w_lsr[s] = i_data[i+s];
                assign w_asr[s] = i_data[i+s];
            end else begin : g_hi_fill
                assign w_lsr[s] = 1'b0;
                assign w_asr[s] = i_data[WIDTH-1];
            end

            assign w_ror[s] = i_data[(i+s) % WIDTH];
        end

        always_comb begin
            w_sel = w_lsl;
            case (i_op)
                OP_LSL:  w_sel = w_lsl;
                OP_LSR:  w_sel = w_lsr;
                OP_ASR:  w_sel = w_asr;
                OP_ROR:  w_sel = w_ror;
                default: w_sel = w_lsl;
            endcase
        end

        assign o_data[i] = w_sel[i_step];
    end

endmodule

// File: rtl/seq_shifter.sv
// Sequential shifter: reuses one 0..3 shift stage per cycle until the requested amount is consumed.
//
// state   | meaning
// S_IDLE  | waiting for an operand, in_ready high
// S_SHIFT | applying up to MAX_STEP positions per cycle
// S_DONE  | result held on d_out until out_ready
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input logic         i_clk,
    input logic         i_reset,
    seq_shifter_if.slave bus
);

    localparam int SW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_d_out;
    logic [WIDTH-1:0] w_step_data;
    logic [SW-1:0]    r_rem;
    logic [SW-1:0]    w_rem_nxt;
    op_t              r_op;
    logic             r_out_valid;
    logic [1:0]       w_step;
    logic             w_accept;
    logic             w_last;

    assign w_step    = (r_rem > SW'(MAX_STEP)) ? 2'(MAX_STEP) : r_rem[1:0];
    assign w_rem_nxt = r_rem - SW'(w_step);
    assign w_last    = (w_rem_nxt == '0);

    assign bus.in_ready  = (r_state == S_IDLE) && !i_reset;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.d_out     = r_d_out;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .i_data (r_data),
        .i_op   (r_op),
        .i_step (w_step),
        .o_data (w_step_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)      w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)        w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_data      <= '0;
            r_rem       <= '0;
            r_op        <= OP_LSL;
            r_out_valid <= 1'b0;
            r_d_out     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data <= bus.d_in;
                        r_rem  <= bus.shamt;
                        r_op   <= bus.op;
                    end
                end
                S_SHIFT: begin
                    r_data <= w_step_data;
                    r_rem  <= w_rem_nxt;
                    // Result register is loaded only on the last step so it stays frozen in S_DONE.
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_d_out     <= w_step_data;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Randomised and directed checks of seq_shifter against an arithmetic shift model.
module tb_seq_shifter;
    import shifter_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    seq_shifter_if #(.WIDTH(WIDTH)) bus ();

    seq_shifter #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input int s, input op_t o);
        logic [63:0] dd;
        dd = {d, d} >> s;
        case (o)
            OP_LSL:  return d << s;
            OP_LSR:  return d >> s;
            OP_ASR:  return 32'($signed(d) >>> s);
            default: return dd[31:0];
        endcase
    endfunction

    function automatic int model_lat(input int s);
        return (s == 0) ? 2 : ((s + 2) / 3) + 1;
    endfunction

    task automatic run_op(input logic [31:0] d, input int s, input op_t o,
                          input int hold, input string tag);
        logic [31:0] exp;
        int          lat;
        exp = model(d, s, o);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.d_in      = d;
        bus.shamt     = 5'(s);
        bus.op        = o;
        bus.out_ready = 1'b0;
        #1 check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        lat = 1;
        bus.in_valid = 1'b0;
        bus.d_in     = $urandom;
        bus.shamt    = 5'($urandom_range(0, 31));
        bus.op       = op_t'($urandom_range(0, 3));
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(model_lat(s)));
        check({tag, "_d_out"}, bus.d_out, exp);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            #1;
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, "_hold_data"}, bus.d_out, exp);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_release_ready"}, 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.d_in      = '0;
        bus.shamt     = '0;
        bus.op        = OP_LSL;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_d_out", bus.d_out, 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

        run_op(32'h8000_00F0, 4,  OP_LSR, 0, "lsr4");
        run_op(32'h8000_0000, 31, OP_ASR, 1, "asr31");
        run_op(32'h7000_0000, 28, OP_ASR, 0, "asr28");
        run_op(32'h0000_0001, 31, OP_LSL, 0, "lsl31");
        run_op(32'h0000_0001, 1,  OP_ROR, 0, "ror1");
        run_op(32'h1234_5678, 16, OP_ROR, 2, "ror16");
        run_op(32'h1234_5678, 3,  OP_LSL, 0, "lsl3");
        for (int o = 0; o < 4; o++) run_op(32'hDEAD_BEEF, 0, op_t'(o), 0, "zero");
        run_op(32'hCAFE_F00D, 13, OP_ROR, 5, "backpressure");
        run_op(32'h0F0F_0F0F, 7,  OP_LSL, 0, "after_bp");

        // Reset in the middle of a long shift; previous d_out is nonzero.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.d_in     = 32'hFFFF_0000;
        bus.shamt    = 5'd20;
        bus.op       = OP_LSR;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check("mid_reset_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("mid_reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_reset_d_out", bus.d_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("mid_reset_release", 32'(bus.in_ready), 32'd1);
        run_op(32'hFFFF_0000, 20, OP_LSR, 0, "after_reset");

        for (int n = 0; n < 40; n++) begin
            run_op($urandom, $urandom_range(0, 31), op_t'($urandom_range(0, 3)),
                   $urandom_range(0, 3), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
